// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the stage sequencer
// Purpose: sequencer state encoding and PC width, imported by the
//          interface, the watchdog and the top.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERROR
  } seq_state_t;

  localparam int PC_W = 32;

endpackage

// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - core <-> sequencer signal bundle
// Purpose: groups the control, completion, PC and status signals.
// Ports (modports):
//   master - sequencer side: takes run/step/stage_completed/pc_next,
//            drives stage_enable/stage_rstn/stage_latch/pc/stage_idx/
//            busy/retired/cycles/timeout_err.
//   slave  - core side, opposite directions.
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 32
);
  import seq_pkg::*;

  localparam int IDX_W = $clog2(NUM_STAGES);

  logic                  run;
  logic                  step;
  logic [NUM_STAGES-1:0] stage_completed;
  logic [PC_W-1:0]       pc_next;
  logic [NUM_STAGES-1:0] stage_enable;
  logic [NUM_STAGES-1:0] stage_rstn;
  logic [NUM_STAGES-1:0] stage_latch;
  logic [PC_W-1:0]       pc;
  logic [IDX_W-1:0]      stage_idx;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  retired;
  logic [CNT_WIDTH-1:0]  cycles;
  logic                  timeout_err;

  modport master (
    input  run, step, stage_completed, pc_next,
    output stage_enable, stage_rstn, stage_latch, pc, stage_idx,
           busy, retired, cycles, timeout_err
  );

  modport slave (
    output run, step, stage_completed, pc_next,
    input  stage_enable, stage_rstn, stage_latch, pc, stage_idx,
           busy, retired, cycles, timeout_err
  );

endinterface

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage residency counter with expiry flag
// Purpose: counts cycles already spent in the current stage; expired is
//          high in the TIMEOUT-th cycle of a stage. TIMEOUT=0 disables it.
// Ports: clk, rstn (async active-low), clear (a stage is entered at the
//        next edge), active (sequencer is running), expired (out).
module stage_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clear || !active) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  // count_q is 0 in the entry cycle, so LIMIT marks the TIMEOUT-th cycle.
  assign expired = EN && active && (count_q == LIMIT);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - N-stage instruction sequencer with PC, counters, watchdog
// Purpose: steps an instruction through NUM_STAGES stages, pulsing enables,
//          holding the active stage out of reset and strobing latches.
// Ports: clk, rstn (async active-low), bus (stage_sequencer_if.master).
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int              NUM_STAGES = 4,
  parameter int              PC_STAGE   = 2,
  parameter int              TIMEOUT    = 255,
  parameter logic [PC_W-1:0] PC_RESET   = 32'h0,
  parameter int              CNT_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               rstn,
  stage_sequencer_if.master  bus
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(PC_STAGE);
  localparam logic [NUM_STAGES-1:0] ONE = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  seq_state_t            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  step_pending_q;
  logic                  step_set, done, enter, expired;
  logic [NUM_STAGES-1:0] sel_q, sel_d;
  logic [NUM_STAGES-1:0] enable_q, stage_rstn_q;
  logic [PC_W-1:0]       pc_q;
  logic [CNT_WIDTH-1:0]  retired_q, cycles_q;
  logic                  timeout_err_q;

  assign sel_q    = ONE << idx_q;
  assign sel_d    = ONE << idx_d;
  assign done     = (state_q == RUN) && bus.stage_completed[idx_q];
  assign step_set = bus.step && !bus.run && !step_pending_q;

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (enter),
    .active  (state_q == RUN),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    enter   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run || step_pending_q) begin
          state_d = RUN;
          idx_d   = '0;
          enter   = 1'b1;
        end
      end
      RUN: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (done) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            // A step arriving with the last completion chains without a gap.
            if (bus.run || step_pending_q || step_set) begin
              enter = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            enter = 1'b1;
          end
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      default: ;  // ERROR is left only through reset
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      step_pending_q <= 1'b0;
      enable_q       <= '0;
      stage_rstn_q   <= '0;
      pc_q           <= PC_RESET;
      retired_q      <= '0;
      cycles_q       <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      enable_q     <= enter ? sel_d : '0;
      stage_rstn_q <= (state_d == RUN) ? sel_d : '0;
      if (enter && (idx_d == '0)) begin
        step_pending_q <= 1'b0;
      end else if (step_set) begin
        step_pending_q <= 1'b1;
      end
      if (done && (idx_q == PC_IDX)) begin
        pc_q <= bus.pc_next;
      end
      if (done && (idx_q == LAST_IDX)) begin
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
      if (state_q == RUN) begin
        cycles_q <= cycles_q + CNT_WIDTH'(1);
      end
      if (state_d == ERROR) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign bus.stage_enable = enable_q;
  assign bus.stage_rstn   = stage_rstn_q;
  assign bus.stage_latch  = done ? sel_q : '0;
  assign bus.pc           = pc_q;
  assign bus.stage_idx    = idx_q;
  assign bus.busy         = (state_q == RUN);
  assign bus.retired      = retired_q;
  assign bus.cycles       = cycles_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - self-checking bench for stage_sequencer
module tb_stage_sequencer;

  localparam int NS  = 4;
  localparam int PCS = 2;
  localparam int TO  = 4;
  localparam int CW  = 32;
  localparam logic [31:0] PCR = 32'h0000_1000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  stage_sequencer_if #(.NUM_STAGES(NS), .CNT_WIDTH(CW)) bus_if ();

  stage_sequencer #(
    .NUM_STAGES(NS), .PC_STAGE(PCS), .TIMEOUT(TO), .PC_RESET(PCR), .CNT_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [3:0] c, input logic [31:0] p);
    bus_if.run             = r;
    bus_if.step            = s;
    bus_if.stage_completed = c;
    bus_if.pc_next         = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_en"},   32'(bus_if.stage_enable), 32'h0);
    chk({tag, "_rs"},   32'(bus_if.stage_rstn),   32'h0);
    chk({tag, "_la"},   32'(bus_if.stage_latch),  32'h0);
    chk({tag, "_pc"},   bus_if.pc,                PCR);
    chk({tag, "_idx"},  32'(bus_if.stage_idx),    32'h0);
    chk({tag, "_busy"}, 32'(bus_if.busy),         32'h0);
    chk({tag, "_ret"},  bus_if.retired,           32'h0);
    chk({tag, "_cyc"},  bus_if.cycles,            32'h0);
    chk({tag, "_err"},  32'(bus_if.timeout_err),  32'h0);
  endtask

  // Reference model: tracks which stage is active, when it was entered
  // and the architectural counters; stage residency is a time difference.
  int          m_mode;      // 0 idle, 1 running, 2 watchdog error
  int          m_stage;
  bit          m_pend;
  longint      m_now, m_t_enter;
  logic [31:0] m_pc, m_ret, m_cyc;
  logic        r_run, r_step;
  logic [3:0]  r_comp;
  logic [31:0] r_pcn;

  task automatic model_reset();
    m_mode = 0; m_stage = 0; m_pend = 1'b0;
    m_now = 0; m_t_enter = -1;
    m_pc = PCR; m_ret = 0; m_cyc = 0;
  endtask

  task automatic model_enter(input int s);
    m_stage   = s;
    m_t_enter = m_now + 1;
  endtask

  task automatic model_advance();
    bit step_new;
    step_new = r_step && !r_run && !m_pend;
    if (m_mode == 0) begin
      if (r_run || m_pend) begin
        m_mode = 1; model_enter(0); m_pend = 1'b0;
      end else if (step_new) begin
        m_pend = 1'b1;
      end
    end else if (m_mode == 1) begin
      m_cyc = m_cyc + 1;
      if (r_comp[m_stage]) begin
        if (m_stage == PCS) m_pc = r_pcn;
        if (m_stage == NS - 1) begin
          m_ret = m_ret + 1;
          if (r_run || m_pend || step_new) begin
            model_enter(0); m_pend = 1'b0;
          end else begin
            m_mode = 0; m_stage = 0;
          end
        end else begin
          model_enter(m_stage + 1);
          if (step_new) m_pend = 1'b1;
        end
      end else if (m_now - m_t_enter + 1 == TO) begin
        m_mode = 2;
      end else if (step_new) begin
        m_pend = 1'b1;
      end
    end
    m_now++;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] onehot;
    onehot = 4'(1 << m_stage);
    chk({tag, "_en"},   32'(bus_if.stage_enable),
        (m_mode == 1 && m_t_enter == m_now) ? 32'(onehot) : 32'h0);
    chk({tag, "_rs"},   32'(bus_if.stage_rstn), (m_mode == 1) ? 32'(onehot) : 32'h0);
    chk({tag, "_la"},   32'(bus_if.stage_latch),
        (m_mode == 1 && r_comp[m_stage]) ? 32'(onehot) : 32'h0);
    chk({tag, "_pc"},   bus_if.pc, m_pc);
    chk({tag, "_idx"},  32'(bus_if.stage_idx), 32'(m_stage));
    chk({tag, "_busy"}, 32'(bus_if.busy), (m_mode == 1) ? 32'h1 : 32'h0);
    chk({tag, "_ret"},  bus_if.retired, m_ret);
    chk({tag, "_cyc"},  bus_if.cycles, m_cyc);
    chk({tag, "_err"},  32'(bus_if.timeout_err), (m_mode == 2) ? 32'h1 : 32'h0);
  endtask

  typedef struct {
    logic        run;
    logic [3:0]  comp;
    logic [31:0] pcn;
    logic [3:0]  en, rs, la;
    logic [1:0]  idx;
    logic        busy;
    logic [31:0] pc, ret, cyc;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // run, comp, pc_next | enable, stage_rstn, latch, idx, busy, pc, retired, cycles
    tbl[0] = '{1'b1, 4'b0000, 32'h00, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, PCR,   32'd0, 32'd0};
    tbl[1] = '{1'b1, 4'b0000, 32'h00, 4'h1, 4'h1, 4'h0, 2'd0, 1'b1, PCR,   32'd0, 32'd0};
    tbl[2] = '{1'b1, 4'b0001, 32'h77, 4'h0, 4'h1, 4'h1, 2'd0, 1'b1, PCR,   32'd0, 32'd1};
    tbl[3] = '{1'b1, 4'b1000, 32'h00, 4'h2, 4'h2, 4'h0, 2'd1, 1'b1, PCR,   32'd0, 32'd2};
    tbl[4] = '{1'b1, 4'b1010, 32'h77, 4'h0, 4'h2, 4'h2, 2'd1, 1'b1, PCR,   32'd0, 32'd3};
    tbl[5] = '{1'b1, 4'b0000, 32'h40, 4'h4, 4'h4, 4'h0, 2'd2, 1'b1, PCR,   32'd0, 32'd4};
    tbl[6] = '{1'b1, 4'b0100, 32'h40, 4'h0, 4'h4, 4'h4, 2'd2, 1'b1, PCR,   32'd0, 32'd5};
    tbl[7] = '{1'b0, 4'b0000, 32'h99, 4'h8, 4'h8, 4'h0, 2'd3, 1'b1, 32'h40, 32'd0, 32'd6};
    tbl[8] = '{1'b0, 4'b1000, 32'h99, 4'h0, 4'h8, 4'h8, 2'd3, 1'b1, 32'h40, 32'd0, 32'd7};
    tbl[9] = '{1'b0, 4'b0000, 32'h00, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 32'h40, 32'd1, 32'd8};

    drive(1'b0, 1'b0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].run, 1'b0, tbl[i].comp, tbl[i].pcn);
      #1;
      chk($sformatf("tbl%0d_en", i),   32'(bus_if.stage_enable), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_rs", i),   32'(bus_if.stage_rstn),   32'(tbl[i].rs));
      chk($sformatf("tbl%0d_la", i),   32'(bus_if.stage_latch),  32'(tbl[i].la));
      chk($sformatf("tbl%0d_idx", i),  32'(bus_if.stage_idx),    32'(tbl[i].idx));
      chk($sformatf("tbl%0d_busy", i), 32'(bus_if.busy),         32'(tbl[i].busy));
      chk($sformatf("tbl%0d_pc", i),   bus_if.pc,                tbl[i].pc);
      chk($sformatf("tbl%0d_ret", i),  bus_if.retired,           tbl[i].ret);
      chk($sformatf("tbl%0d_cyc", i),  bus_if.cycles,            tbl[i].cyc);
      @(negedge clk);
    end

    // Single-step with zero-latency stages: one 4-cycle instruction per step.
    do_reset();
    drive(1'b0, 1'b1, 4'hF, 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 4'hF, 32'h0); #1;
    chk("step_pending_idle", 32'(bus_if.busy), 32'h0);
    @(negedge clk); #1;
    chk("step_start_en",   32'(bus_if.stage_enable), 32'h1);
    chk("step_start_busy", 32'(bus_if.busy), 32'h1);
    repeat (4) @(negedge clk); #1;
    chk("step1_busy", 32'(bus_if.busy), 32'h0);
    chk("step1_rs",   32'(bus_if.stage_rstn), 32'h0);
    chk("step1_ret",  bus_if.retired, 32'd1);
    chk("step1_cyc",  bus_if.cycles, 32'd4);
    drive(1'b0, 1'b1, 4'hF, 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 4'hF, 32'h0);
    repeat (5) @(negedge clk); #1;
    chk("step2_ret", bus_if.retired, 32'd2);
    chk("step2_cyc", bus_if.cycles, 32'd8);

    // Step coinciding with the last stage completion chains with no gap.
    do_reset();
    drive(1'b0, 1'b1, 4'hF, 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 4'hF, 32'h0);
    repeat (4) @(negedge clk);
    drive(1'b0, 1'b1, 4'hF, 32'h0); #1;
    chk("chain_last_la", 32'(bus_if.stage_latch), 32'h8);
    @(negedge clk); drive(1'b0, 1'b0, 4'hF, 32'h0); #1;
    chk("chain_en",   32'(bus_if.stage_enable), 32'h1);
    chk("chain_busy", 32'(bus_if.busy), 32'h1);
    repeat (4) @(negedge clk); #1;
    chk("chain_ret",  bus_if.retired, 32'd2);
    chk("chain_cyc",  bus_if.cycles, 32'd8);
    chk("chain_busy_end", 32'(bus_if.busy), 32'h0);

    // Watchdog: stage 1 never completes.
    do_reset();
    drive(1'b1, 1'b0, 4'b0001, 32'h0);
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    repeat (3) @(negedge clk); #1;
    chk("wd_last_busy", 32'(bus_if.busy), 32'h1);
    chk("wd_last_err",  32'(bus_if.timeout_err), 32'h0);
    chk("wd_last_idx",  32'(bus_if.stage_idx), 32'h1);
    @(negedge clk); drive(1'b1, 1'b0, 4'hF, 32'h0); #1;
    chk("wd_err",  32'(bus_if.timeout_err), 32'h1);
    chk("wd_busy", 32'(bus_if.busy), 32'h0);
    chk("wd_rs",   32'(bus_if.stage_rstn), 32'h0);
    chk("wd_en",   32'(bus_if.stage_enable), 32'h0);
    chk("wd_la",   32'(bus_if.stage_latch), 32'h0);
    repeat (3) @(negedge clk); #1;
    chk("wd_hold_err",  32'(bus_if.timeout_err), 32'h1);
    chk("wd_hold_busy", 32'(bus_if.busy), 32'h0);

    // Completion in the expiry cycle wins.
    do_reset();
    drive(1'b1, 1'b0, 4'b0001, 32'h0);
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b0, 4'b0000, 32'h0);
    repeat (3) @(negedge clk);
    drive(1'b1, 1'b0, 4'b0010, 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 4'hF, 32'h0); #1;
    chk("race_idx",  32'(bus_if.stage_idx), 32'h2);
    chk("race_err",  32'(bus_if.timeout_err), 32'h0);
    chk("race_busy", 32'(bus_if.busy), 32'h1);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of stage 2.
    do_reset();
    drive(1'b1, 1'b0, 4'hF, 32'h55);
    repeat (5) @(negedge clk);
    drive(1'b1, 1'b0, 4'b0011, 32'h66);
    repeat (2) @(negedge clk); #1;
    chk("arst_pre_idx", 32'(bus_if.stage_idx), 32'h2);
    chk("arst_pre_pc",  bus_if.pc, 32'h55);
    chk("arst_pre_ret", bus_if.retired, 32'd1);
    #1 rstn = 1'b0;
    #1 check_reset("arst");
    @(negedge clk);
    rstn = 1'b1;

    // Randomised run against the reference model.
    r_run = 1'b0; r_step = 1'b0; r_comp = 4'h0; r_pcn = 32'h0;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        rstn = 1'b0;
        #1;
        model_reset();
        check_model("rnd_rst");
        @(posedge clk);
        #1 rstn = 1'b1;
      end else begin
        if ($urandom_range(0, 15) == 0) r_run = ~r_run;
        r_step = ($urandom_range(0, 7) == 0);
        for (int b = 0; b < NS; b++) r_comp[b] = ($urandom_range(0, 9) < 6);
        r_pcn = $urandom;
        drive(r_run, r_step, r_comp, r_pcn);
        #1;
        check_model("rnd");
        @(posedge clk);
        model_advance();
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
